wb_bus_arbiter: RTL
===================

// Module: wb_bus_arbiter
// PURPOSE
//  Two-requester arbiter and sequencer for the CPU's single Wishbone master port.
//  Shares the bus between the IF (fetch) and MEM (load/store) requesters and runs one classic
//  Wishbone cycle at a time. Drives stall requests to ctrl, cancels fetches on flush_i and
//  recovers from hung slaves via a timeout. Sits between the IF/MEM stages and the SoC bus.
// PARAMETERS
//  TIMEOUT     255  cycles without wb_ack_i before a transaction is abandoned (8-bit counter)
//  STARVE_MAX  4    consecutive MEM grants while IF waits before IF is forced a grant
// PORTS
//  clk            in   1   clock; all state changes on rising edge
//  rst            in   1   asynchronous, active-low reset
//  flush_i        in   1   pipeline flush from ctrl
//  if_req_i       in   1   fetch request; held until if_ack_o
//  if_addr_i      in   32  fetch address
//  if_rdata_o     out  32  fetched word, valid when if_ack_o=1
//  if_ack_o       out  1   one-cycle completion pulse to IF
//  stall_req_if   out  1   IF must stall
//  mem_req_i      in   1   load/store request; held until mem_ack_o
//  mem_we_i       in   1   1=store
//  mem_sel_i      in   4   byte enables
//  mem_addr_i     in   32  load/store address
//  mem_wdata_i    in   32  store data
//  mem_rdata_o    out  32  load data, valid when mem_ack_o=1
//  mem_ack_o      out  1   one-cycle completion pulse to MEM
//  stall_req_mem  out  1   MEM must stall
//  wb_cyc_o/wb_stb_o  out  1   Wishbone cycle/strobe (always equal)
//  wb_we_o        out  1   Wishbone write enable
//  wb_sel_o       out  4   Wishbone byte select
//  wb_adr_o       out  32  Wishbone address
//  wb_dat_o       out  32  Wishbone write data
//  wb_dat_i       in   32  Wishbone read data
//  wb_ack_i       in   1   Wishbone acknowledge
//  bus_err_o      out  1   one-cycle pulse on timeout
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; all outputs 0; rdata regs, counters, cancel flag cleared.
//  - States: IDLE, IF_ACC, MEM_ACC. All wb_* outputs are registered and loaded at grant.
//  - IDLE arbitration (edge N):
//    - mem_req_i wins unless if_req_i=1 and starve_cnt==STARVE_MAX; then IF wins.
//    - if_req_i is ignored while flush_i=1.
//    - Winner's addr/sel/we/wdata latched; wb_cyc_o/wb_stb_o=1 after edge N.
//    - IF grant drives wb_sel_o=4'hF, wb_we_o=0, wb_dat_o=0.
//  - ACC: wb_* held stable until wb_ack_i. On the ack edge:
//    - wb_dat_i is captured into the owner's rdata.
//    - Owner's ack_o is 1 for exactly the next cycle.
//    - wb_cyc_o/wb_stb_o drop and state returns to IDLE; at least one idle cycle separates transactions.
//  - Latency: request to ack_o is 2 cycles with a zero-wait slave; each slave wait state adds 1.
//  - Stores write wb_dat_o/wb_sel_o straight from MEM; no read-modify-write. mem_rdata_o is unchanged on stores.
//  - stall_req_x = x_req_i & ~x_ack_o (combinational); a new request stalls in its first cycle.
//  - starve_cnt: +1 on each MEM grant taken while if_req_i=1, saturating at STARVE_MAX; cleared on IF grant.
//  - Flush during IF_ACC: the Wishbone cycle still completes, since it cannot be aborted, and the cancel flag is set.
//    - On ack: no if_ack_o pulse and if_rdata_o is unchanged; cancel then clears.
//    - flush_i in the same cycle as wb_ack_i also counts as a cancel.
//  - flush_i has no effect on MEM_ACC; stores in flight always complete.
//  - Timeout: tcnt clears at grant and increments in ACC while wb_ack_i=0. When tcnt==TIMEOUT:
//    - wb_cyc_o/wb_stb_o drop; bus_err_o pulses once.
//    - Owner ack_o pulses with rdata=0 (suppressed if cancelled); state returns to IDLE.
//    - A wb_ack_i arriving in the same cycle wins, and no error is raised.
//  - wb_ack_i seen in IDLE (stray ack) is ignored.
//  - Reset asserted mid-transaction: immediate IDLE; cyc/stb drop asynchronously.
// STRUCTURE
//  - defines.v holds:
//    - state encodings `WBA_IDLE/`WBA_IF/`WBA_MEM (2 bits)
//    - `WB_SEL_ALL 4'hF
//    - reuse of `ZeroWord, `True_v/`False_v, `Stop/`NoStop
//  - Sub-module wb_timeout_cnt (clear, enable, hit output; width 8) handles the timeout.
//  - Arbitration, FSM and output registers stay in this module.
// TESTING
//  - IF read at 0xBFC00000, slave acks after 0 waits:
//    - cyc 1 cycle after req; if_ack_o 2 cycles after req; if_rdata_o=slave word; stall_req_if=1 until ack.
//  - if_req_i and mem_req_i both raised (store 0x80001000, sel=4'b0011, data 0x0000BEEF):
//    - MEM served first with wb_we_o=1, sel 4'b0011; IF served next.
//  - mem_req_i held continuously and if_req_i pending:
//    - after 4 MEM grants the 5th grant goes to IF; starve_cnt resets.
//  - flush_i pulsed 1 cycle into IF_ACC, slave acks 3 cycles later:
//    - no if_ack_o; if_rdata_o unchanged; next IF request served normally.
//  - Slave never acks MEM load:
//    - after 255 cycles cyc drops, bus_err_o=1 for 1 cycle, mem_ack_o=1 with mem_rdata_o=0.
//  - rst driven low mid-MEM_ACC:
//    - wb_cyc_o=0 and all outputs 0 before next edge; after release a pending req is granted normally.

Source files
------------

// File: rtl/wb_bus_arbiter_pkg.sv
// Shared encodings and the latched Wishbone request record for the IF/MEM bus arbiter.
// State codes keep the legacy 2-bit values so existing trace decoders still apply.
package wb_bus_arbiter_pkg;

  localparam logic [1:0] WBA_IDLE = 2'd0;
  localparam logic [1:0] WBA_IF   = 2'd1;
  localparam logic [1:0] WBA_MEM  = 2'd2;

  localparam logic [3:0]  WB_SEL_ALL = 4'hF;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Watchdog for one Wishbone transaction: counts unacknowledged cycles and flags when LIMIT is reached.
module wb_timeout_cnt #(
  parameter int W     = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !hit) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == LIMIT_V);

endmodule

// File: rtl/wb_bus_arbiter.sv
// Shares the single Wishbone master port between fetch (IF) and load/store (MEM), one
// classic cycle at a time, with IF anti-starvation, flush cancellation and a hung-slave timeout.
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT    = 255,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  output logic        stall_req_if,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        stall_req_mem,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        bus_err_o,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester raises x_req_i and holds it, with its operands stable, until the
  // single-cycle x_ack_o pulse; no new grant is issued in a cycle where any x_ack_o is high,
  // so a still-high request seen in its ack cycle is never mistaken for a fresh one.

  // STARVE_MAX must fit the 3-bit starvation counter.
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [1:0] state;
  logic [2:0] starve_cnt;
  logic       cancel;
  logic       cyc_q;
  wb_req_t    bus_q;

  logic if_live;
  logic grant_if;
  logic grant_mem;
  logic if_drop;
  logic tmo_clear;
  logic tmo_en;
  logic tmo_hit;

  always_comb begin
    if_live   = if_req_i & ~flush_i;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    if (state == WBA_IDLE && !if_ack_o && !mem_ack_o) begin
      if (if_live && (!mem_req_i || starve_cnt == STARVE_LIM)) begin
        grant_if = 1'b1;
      end else if (mem_req_i) begin
        grant_mem = 1'b1;
      end
    end
    if_drop   = cancel | flush_i;
    tmo_clear = grant_if | grant_mem;
    tmo_en    = (state != WBA_IDLE) & ~wb_ack_i;
  end

  wb_timeout_cnt #(
    .W     (8),
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear),
    .enable (tmo_en),
    .hit    (tmo_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= WBA_IDLE;
      starve_cnt  <= '0;
      cancel      <= 1'b0;
      cyc_q       <= 1'b0;
      bus_q       <= '0;
      if_rdata_o  <= ZERO_WORD;
      mem_rdata_o <= ZERO_WORD;
      if_ack_o    <= 1'b0;
      mem_ack_o   <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      if_ack_o  <= 1'b0;
      mem_ack_o <= 1'b0;
      bus_err_o <= 1'b0;
      case (state)
        WBA_IDLE: begin
          if (grant_if) begin
            state      <= WBA_IF;
            cyc_q      <= 1'b1;
            bus_q      <= '{we: 1'b0, sel: WB_SEL_ALL, adr: if_addr_i, dat: ZERO_WORD};
            starve_cnt <= '0;
            cancel     <= 1'b0;
          end else if (grant_mem) begin
            state <= WBA_MEM;
            cyc_q <= 1'b1;
            bus_q <= '{we: mem_we_i, sel: mem_sel_i, adr: mem_addr_i, dat: mem_wdata_i};
            if (if_req_i && starve_cnt != STARVE_LIM) begin
              starve_cnt <= starve_cnt + 3'd1;
            end
          end
        end
        WBA_IF: begin
          // A real ack takes priority over a timeout landing in the same cycle.
          if (wb_ack_i || tmo_hit) begin
            state     <= WBA_IDLE;
            cyc_q     <= 1'b0;
            cancel    <= 1'b0;
            bus_err_o <= ~wb_ack_i;
            if (!if_drop) begin
              if_ack_o   <= 1'b1;
              if_rdata_o <= wb_ack_i ? wb_dat_i : ZERO_WORD;
            end
          end else if (flush_i) begin
            cancel <= 1'b1;
          end
        end
        WBA_MEM: begin
          if (wb_ack_i || tmo_hit) begin
            state     <= WBA_IDLE;
            cyc_q     <= 1'b0;
            bus_err_o <= ~wb_ack_i;
            mem_ack_o <= 1'b1;
            if (!wb_ack_i) begin
              mem_rdata_o <= ZERO_WORD;
            end else if (!bus_q.we) begin
              mem_rdata_o <= wb_dat_i;
            end
          end
        end
        default: begin
          state <= WBA_IDLE;
          cyc_q <= 1'b0;
        end
      endcase
    end
  end

  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign wb_we_o       = bus_q.we;
  assign wb_sel_o      = bus_q.sel;
  assign wb_adr_o      = bus_q.adr;
  assign wb_dat_o      = bus_q.dat;
  assign stall_req_if  = if_req_i & ~if_ack_o;
  assign stall_req_mem = mem_req_i & ~mem_ack_o;
  assign dbg_state     = state;

endmodule
